// File: rtl/pbvi_pkg.sv
// Shared definitions for the PBVI backup datapath: action codes, FSM states
// and the index-to-action-code mapping.
package pbvi_pkg;

  localparam logic [1:0] ACT_NONE = 2'b00;
  localparam logic [1:0] ACT_A1   = 2'b01;
  localparam logic [1:0] ACT_A2   = 2'b10;
  localparam logic [1:0] ACT_A3   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_FINISH
  } state_t;

  function automatic logic [1:0] act_code(input logic [1:0] idx);
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/pbvi_dot2.sv
// Two-component unsigned dot product s0*g0 + s1*g1 with a full-width result.
module pbvi_dot2 #(
  parameter int unsigned dw = 16
) (
  input  logic [dw-1:0]   i_s0,
  input  logic [dw-1:0]   i_s1,
  input  logic [dw-1:0]   i_g0,
  input  logic [dw-1:0]   i_g1,
  output logic [2*dw:0]   o_value
);

  logic [2*dw-1:0] w_p0;
  logic [2*dw-1:0] w_p1;

  always_comb begin
    w_p0    = (2*dw)'(i_s0) * (2*dw)'(i_g0);
    w_p1    = (2*dw)'(i_s1) * (2*dw)'(i_g1);
    o_value = (2*dw+1)'(w_p0) + (2*dw+1)'(w_p1);
  end

endmodule

// File: rtl/pbvi_backup_ctrl.sv
// PBVI backup/argmax sequencer: sweeps all (belief, action) pairs through one
// shared dot-product unit and writes the best action per belief.
module pbvi_backup_ctrl
  import pbvi_pkg::*;
#(
  parameter int unsigned num_b = 16,
  parameter int unsigned num_a = 3,
  parameter int unsigned dw    = 16,
  localparam int unsigned BW   = (num_b > 1) ? $clog2(num_b) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            rd_en,
  output logic [BW-1:0]   rd_b,
  output logic [1:0]      rd_a,
  input  logic [dw-1:0]   s0_in,
  input  logic [dw-1:0]   s1_in,
  input  logic [dw-1:0]   g0_in,
  input  logic [dw-1:0]   g1_in,
  output logic            wr_en,
  output logic [BW-1:0]   wr_b,
  output logic [2*dw:0]   wr_value,
  output logic [dw-1:0]   wr_alpha0,
  output logic [dw-1:0]   wr_alpha1,
  output logic [1:0]      wr_action
);

  localparam logic [BW-1:0] LAST_B = BW'(num_b - 1);
  localparam logic [1:0]    LAST_A = 2'(num_a - 1);

  state_t r_state;
  state_t w_next;

  logic [BW-1:0] r_b;
  logic [1:0]    r_a;
  logic          w_rd_en;
  logic          w_last_issue;

  logic          r_valid;
  logic [BW-1:0] r_pb;
  logic [1:0]    r_pa;

  logic [2*dw:0] w_value;
  logic          w_take;
  logic [2*dw:0] w_cand_value;
  logic [dw-1:0] w_cand_alpha0;
  logic [dw-1:0] w_cand_alpha1;
  logic [1:0]    w_cand_action;

  logic [2*dw:0] r_best_value;
  logic [dw-1:0] r_best_alpha0;
  logic [dw-1:0] r_best_alpha1;
  logic [1:0]    r_best_action;

  logic          r_wr_en;
  logic [BW-1:0] r_wr_b;
  logic [2*dw:0] r_wr_value;
  logic [dw-1:0] r_wr_alpha0;
  logic [dw-1:0] r_wr_alpha1;
  logic [1:0]    r_wr_action;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (start) w_next = ST_ISSUE;
      ST_ISSUE:  if (w_rd_en && w_last_issue) w_next = ST_DRAIN;
      // The last read lands on the first DRAIN cycle; leave once its write is out.
      ST_DRAIN:  if (r_wr_en && !r_valid) w_next = ST_FINISH;
      ST_FINISH: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy    = (r_state == ST_ISSUE) || (r_state == ST_DRAIN);
    done    = (r_state == ST_FINISH);
    w_rd_en = (r_state == ST_ISSUE) && en;
  end

  assign w_last_issue = (r_b == LAST_B) && (r_a == LAST_A);

  // Issue counters: action is the fast index, wrapping back to (0,0) after the last pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_b <= '0;
      r_a <= '0;
    end else if (w_rd_en) begin
      if (r_a == LAST_A) begin
        r_a <= '0;
        r_b <= w_last_issue ? '0 : r_b + 1'b1;
      end else begin
        r_a <= r_a + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_pb    <= '0;
      r_pa    <= '0;
    end else begin
      r_valid <= w_rd_en;
      if (w_rd_en) begin
        r_pb <= r_b;
        r_pa <= r_a;
      end
    end
  end

  pbvi_dot2 #(.dw(dw)) u_dot2 (
    .i_s0    (s0_in),
    .i_s1    (s1_in),
    .i_g0    (g0_in),
    .i_g1    (g1_in),
    .o_value (w_value)
  );

  // Action 0 seeds the best unconditionally; later actions need a strict win.
  always_comb begin
    w_take        = (r_pa == 2'd0) || (w_value > r_best_value);
    w_cand_value  = w_take ? w_value         : r_best_value;
    w_cand_alpha0 = w_take ? g0_in           : r_best_alpha0;
    w_cand_alpha1 = w_take ? g1_in           : r_best_alpha1;
    w_cand_action = w_take ? act_code(r_pa)  : r_best_action;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_best_value  <= '0;
      r_best_alpha0 <= '0;
      r_best_alpha1 <= '0;
      r_best_action <= ACT_NONE;
      r_wr_en       <= 1'b0;
      r_wr_b        <= '0;
      r_wr_value    <= '0;
      r_wr_alpha0   <= '0;
      r_wr_alpha1   <= '0;
      r_wr_action   <= ACT_NONE;
    end else begin
      r_wr_en <= 1'b0;
      if (r_valid) begin
        r_best_value  <= w_cand_value;
        r_best_alpha0 <= w_cand_alpha0;
        r_best_alpha1 <= w_cand_alpha1;
        r_best_action <= w_cand_action;
        if (r_pa == LAST_A) begin
          r_wr_en     <= 1'b1;
          r_wr_b      <= r_pb;
          r_wr_value  <= w_cand_value;
          r_wr_alpha0 <= w_cand_alpha0;
          r_wr_alpha1 <= w_cand_alpha1;
          r_wr_action <= w_cand_action;
        end
      end
    end
  end

  assign rd_en     = w_rd_en;
  assign rd_b      = r_b;
  assign rd_a      = r_a;
  assign wr_en     = r_wr_en;
  assign wr_b      = r_wr_b;
  assign wr_value  = r_wr_value;
  assign wr_alpha0 = r_wr_alpha0;
  assign wr_alpha1 = r_wr_alpha1;
  assign wr_action = r_wr_action;

endmodule

// File: tb/tb_pbvi_backup_ctrl.sv
// Directed bench for pbvi_backup_ctrl: a 2x3 instance for sequencing/argmax
// and a 1x1 instance for full-width arithmetic.
module tb_pbvi_backup_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: num_b=2, num_a=3
  logic        a_en, a_start, a_busy, a_done, a_rd_en, a_wr_en;
  logic [0:0]  a_rd_b, a_wr_b;
  logic [1:0]  a_rd_a, a_wr_action;
  logic [15:0] a_s0, a_s1, a_g0, a_g1, a_wr_alpha0, a_wr_alpha1;
  logic [32:0] a_wr_value;

  // Instance B: num_b=1, num_a=1
  logic        b_en, b_start, b_busy, b_done, b_rd_en, b_wr_en;
  logic [0:0]  b_rd_b, b_wr_b;
  logic [1:0]  b_rd_a, b_wr_action;
  logic [15:0] b_s0, b_s1, b_g0, b_g1, b_wr_alpha0, b_wr_alpha1;
  logic [32:0] b_wr_value;

  pbvi_backup_ctrl #(.num_b(2), .num_a(3), .dw(16)) u_dut_a (
    .clk(clk), .rst(rst), .en(a_en), .start(a_start), .busy(a_busy), .done(a_done),
    .rd_en(a_rd_en), .rd_b(a_rd_b), .rd_a(a_rd_a),
    .s0_in(a_s0), .s1_in(a_s1), .g0_in(a_g0), .g1_in(a_g1),
    .wr_en(a_wr_en), .wr_b(a_wr_b), .wr_value(a_wr_value),
    .wr_alpha0(a_wr_alpha0), .wr_alpha1(a_wr_alpha1), .wr_action(a_wr_action)
  );

  pbvi_backup_ctrl #(.num_b(1), .num_a(1), .dw(16)) u_dut_b (
    .clk(clk), .rst(rst), .en(b_en), .start(b_start), .busy(b_busy), .done(b_done),
    .rd_en(b_rd_en), .rd_b(b_rd_b), .rd_a(b_rd_a),
    .s0_in(b_s0), .s1_in(b_s1), .g0_in(b_g0), .g1_in(b_g1),
    .wr_en(b_wr_en), .wr_b(b_wr_b), .wr_value(b_wr_value),
    .wr_alpha0(b_wr_alpha0), .wr_alpha1(b_wr_alpha1), .wr_action(b_wr_action)
  );

  // Belief/gamma storage model: data appears the cycle after rd_en
  logic [15:0] sm0 [2];
  logic [15:0] sm1 [2];
  logic [15:0] gm0 [6];
  logic [15:0] gm1 [6];
  logic [15:0] bs0, bs1, bg0, bg1;

  always @(posedge clk) begin
    if (a_rd_en) begin
      a_s0 <= sm0[int'(a_rd_b)];
      a_s1 <= sm1[int'(a_rd_b)];
      a_g0 <= gm0[int'(a_rd_b) * 3 + int'(a_rd_a)];
      a_g1 <= gm1[int'(a_rd_b) * 3 + int'(a_rd_a)];
    end
    if (b_rd_en) begin
      b_s0 <= bs0;
      b_s1 <= bs1;
      b_g0 <= bg0;
      b_g1 <= bg1;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t0       = 0;

  int rd_cnt, wr_cnt, done_cnt, busy_cnt, dup_cnt;
  int first_rd, last_rd, last_wr, done_cyc, last_busy;
  logic [5:0]  seen;
  logic [32:0] cap_val [2];
  logic [15:0] cap_a0  [2];
  logic [15:0] cap_a1  [2];
  logic [1:0]  cap_act [2];
  int b_rd_cnt, b_wr_cnt, b_done_cyc;
  logic [32:0] b_cap_val;
  logic [15:0] b_cap_a0, b_cap_a1;
  logic [1:0]  b_cap_act;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0; busy_cnt = 0; dup_cnt = 0;
    first_rd = -1; last_rd = -1; last_wr = -1; done_cyc = -1; last_busy = -1;
    seen = '0;
    for (int i = 0; i < 2; i++) begin
      cap_val[i] = '0; cap_a0[i] = '0; cap_a1[i] = '0; cap_act[i] = '0;
    end
    b_rd_cnt = 0; b_wr_cnt = 0; b_done_cyc = -1;
    b_cap_val = '0; b_cap_a0 = '0; b_cap_a1 = '0; b_cap_act = '0;
  endtask

  task automatic sample();
    int idx;
    #1;
    if (a_rd_en) begin
      rd_cnt++;
      last_rd = cyc;
      if (first_rd < 0) first_rd = cyc;
      idx = int'(a_rd_b) * 3 + int'(a_rd_a);
      if (idx > 5 || a_rd_a > 2'd2) dup_cnt++;
      else begin
        if (seen[idx]) dup_cnt++;
        seen[idx] = 1'b1;
      end
    end
    if (a_wr_en) begin
      wr_cnt++;
      last_wr = cyc;
      cap_val[int'(a_wr_b)] = a_wr_value;
      cap_a0[int'(a_wr_b)]  = a_wr_alpha0;
      cap_a1[int'(a_wr_b)]  = a_wr_alpha1;
      cap_act[int'(a_wr_b)] = a_wr_action;
    end
    if (a_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (a_busy) begin
      busy_cnt++;
      last_busy = cyc;
    end
    if (b_rd_en) b_rd_cnt++;
    if (b_wr_en) begin
      b_wr_cnt++;
      b_cap_val = b_wr_value; b_cap_a0 = b_wr_alpha0;
      b_cap_a1 = b_wr_alpha1; b_cap_act = b_wr_action;
    end
    if (b_done) b_done_cyc = cyc;
  endtask

  // One bounded 24-cycle window on instance A; rel = cycle offset from t0 (start cycle)
  task automatic run_a(input int stall_at, input int stall_len, input int start2,
                       input int start3, input int rst_at);
    int rel;
    clear_mon();
    t0 = cyc + 1;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      cyc++;
      rel = cyc - t0;
      a_start = (rel == 0) || (rel == start2) || (rel == start3);
      a_en    = !(rel >= stall_at && rel < stall_at + stall_len);
      rst     = (rel == rst_at);
      sample();
    end
    a_start = 1'b0;
    a_en    = 1'b1;
    rst     = 1'b0;
  endtask

  task automatic set_gam(input int a, input logic [15:0] g0, input logic [15:0] g1);
    gm0[a] = g0; gm1[a] = g1; gm0[a + 3] = g0; gm1[a + 3] = g1;
  endtask

  task automatic check_order_results(input string tag);
    check({tag, "_val0"}, 64'(cap_val[0]), 64'd24);
    check({tag, "_a00"},  64'(cap_a0[0]),  64'd3);
    check({tag, "_a10"},  64'(cap_a1[0]),  64'd3);
    check({tag, "_act0"}, 64'(cap_act[0]), 64'd3);
    check({tag, "_val1"}, 64'(cap_val[1]), 64'd24);
    check({tag, "_act1"}, 64'(cap_act[1]), 64'd3);
    check({tag, "_wrcnt"}, 64'(wr_cnt), 64'd2);
    check({tag, "_rdcnt"}, 64'(rd_cnt), 64'd6);
    check({tag, "_seen"}, 64'(seen), 64'h3F);
    check({tag, "_dup"},  64'(dup_cnt), 64'd0);
  endtask

  initial begin
    rst = 1'b1; a_en = 1'b1; a_start = 1'b0; b_en = 1'b1; b_start = 1'b0;
    a_s0 = '0; a_s1 = '0; a_g0 = '0; a_g1 = '0;
    b_s0 = '0; b_s1 = '0; b_g0 = '0; b_g1 = '0;
    sm0[0] = 16'd3; sm1[0] = 16'd5; sm0[1] = 16'd7; sm1[1] = 16'd1;
    set_gam(0, 16'd1, 16'd1); set_gam(1, 16'd2, 16'd2); set_gam(2, 16'd3, 16'd3);
    bs0 = 16'hFFFF; bs1 = 16'hFFFF; bg0 = 16'hFFFF; bg1 = 16'hFFFF;
    clear_mon();
    repeat (3) begin @(negedge clk); cyc++; end
    rst = 1'b0;
    #1;
    check("rst_busy",  64'(a_busy),     64'd0);
    check("rst_done",  64'(a_done),     64'd0);
    check("rst_rden",  64'(a_rd_en),    64'd0);
    check("rst_wren",  64'(a_wr_en),    64'd0);
    check("rst_wrval", 64'(a_wr_value), 64'd0);
    check("rst_rdb",   64'({a_rd_b, a_rd_a}), 64'd0);

    // Ordering / timing
    run_a(-10, 0, -10, -10, -10);
    check_order_results("ord");
    check("ord_first_rd", 64'(first_rd - t0), 64'd1);
    check("ord_last_rd",  64'(last_rd - t0),  64'd6);
    check("ord_last_wr",  64'(last_wr - t0),  64'd8);
    check("ord_done",     64'(done_cyc - t0), 64'd9);
    check("ord_busy_cnt", 64'(busy_cnt),      64'd8);
    check("ord_busy_last", 64'(last_busy - t0), 64'd8);
    check("ord_done_cnt", 64'(done_cnt),      64'd1);

    // Stall: en low during t0+3..t0+5
    run_a(3, 3, -10, -10, -10);
    check_order_results("stall");
    check("stall_done",    64'(done_cyc - t0), 64'd12);
    check("stall_last_rd", 64'(last_rd - t0),  64'd9);

    // Argmax mix: b0 best at a1 (descending), b1 best at a2
    gm0[0] = 16'd3; gm1[0] = 16'd3; gm0[1] = 16'd2; gm1[1] = 16'd2;
    gm0[2] = 16'd1; gm1[2] = 16'd1;
    gm0[3] = 16'd1; gm1[3] = 16'd0; gm0[4] = 16'd2; gm1[4] = 16'd0;
    gm0[5] = 16'd0; gm1[5] = 16'd1;
    run_a(-10, 0, -10, -10, -10);
    check("mix_val0", 64'(cap_val[0]), 64'd24);
    check("mix_act0", 64'(cap_act[0]), 64'd1);
    check("mix_a00",  64'(cap_a0[0]),  64'd3);
    check("mix_val1", 64'(cap_val[1]), 64'd14);
    check("mix_act1", 64'(cap_act[1]), 64'd2);
    check("mix_a01",  64'(cap_a0[1]),  64'd2);
    check("mix_a11",  64'(cap_a1[1]),  64'd0);

    // Ties: every action gives 16, lowest action wins
    sm0[0] = 16'd2; sm1[0] = 16'd2; sm0[1] = 16'd2; sm1[1] = 16'd2;
    set_gam(0, 16'd4, 16'd4); set_gam(1, 16'd4, 16'd4); set_gam(2, 16'd4, 16'd4);
    run_a(-10, 0, -10, -10, -10);
    check("tie_val0", 64'(cap_val[0]), 64'd16);
    check("tie_act0", 64'(cap_act[0]), 64'd1);
    check("tie_a00",  64'(cap_a0[0]),  64'd4);
    check("tie_a10",  64'(cap_a1[0]),  64'd4);
    check("tie_act1", 64'(cap_act[1]), 64'd1);

    // Reset mid-run at t0+4
    sm0[0] = 16'd3; sm1[0] = 16'd5; sm0[1] = 16'd7; sm1[1] = 16'd1;
    set_gam(0, 16'd1, 16'd1); set_gam(1, 16'd2, 16'd2); set_gam(2, 16'd3, 16'd3);
    run_a(-10, 0, -10, -10, 4);
    check("rstmid_wrcnt",   64'(wr_cnt),   64'd0);
    check("rstmid_donecnt", 64'(done_cnt), 64'd0);
    check("rstmid_lastbusy", 64'(last_busy - t0), 64'd4);
    check("rstmid_busy_end", 64'(a_busy),  64'd0);
    run_a(-10, 0, -10, -10, -10);
    check_order_results("after_rst");
    check("after_rst_done", 64'(done_cyc - t0), 64'd9);

    // Start while busy (t0+3) and start coincident with done (t0+9)
    run_a(-10, 0, 3, 9, -10);
    check("sbusy_donecnt", 64'(done_cnt), 64'd1);
    check("sbusy_rdcnt",   64'(rd_cnt),   64'd6);
    check("sbusy_wrcnt",   64'(wr_cnt),   64'd2);
    check("sbusy_lastbusy", 64'(last_busy - t0), 64'd8);

    // rst overrides start in the same cycle
    @(negedge clk); cyc++; rst = 1'b1; a_start = 1'b1;
    @(negedge clk); cyc++; rst = 1'b0; a_start = 1'b0;
    #1;
    check("rststart_busy", 64'(a_busy), 64'd0);
    @(negedge clk); cyc++;
    #1;
    check("rststart_rden", 64'(a_rd_en), 64'd0);

    // Full-width arithmetic on the 1x1 instance (N=1)
    clear_mon();
    t0 = cyc + 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      cyc++;
      b_start = (cyc == t0);
      sample();
    end
    b_start = 1'b0;
    check("w_value",  64'(b_cap_val), 64'h1_FFFC_0002);
    check("w_action", 64'(b_cap_act), 64'd1);
    check("w_alpha0", 64'(b_cap_a0),  64'hFFFF);
    check("w_alpha1", 64'(b_cap_a1),  64'hFFFF);
    check("w_rdcnt",  64'(b_rd_cnt),  64'd1);
    check("w_wrcnt",  64'(b_wr_cnt),  64'd1);
    check("w_done",   64'(b_done_cyc - t0), 64'd4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
